// File: rtl/passthrough_pkg.sv
// Shared types and defaults for the ESC passthrough bridge.
package passthrough_pkg;

   // Bridge direction state; encoding is exposed on the debug status port.
   typedef enum logic [1:0] {
      StIdle   = 2'b00,
      StHostTx = 2'b01,
      StEscTx  = 2'b10
   } state_e;

   localparam int unsigned DEF_CLK_FREQ_HZ = 72_000_000;
   localparam int unsigned DEF_BAUD        = 115_200;
   localparam int unsigned DEF_HOLD_BITS   = 2;
   localparam int unsigned IDLE_CNT_W      = 16;

   // Idle line time, in clock cycles, before the bridge turns the line around.
   function automatic int unsigned hold_cycles(input int unsigned clk_hz,
                                               input int unsigned baud,
                                               input int unsigned bits);
      return (clk_hz / baud) * bits;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level.
module sync_2ff #(
   parameter logic RESET_VALUE = 1'b1
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_d,
   output logic o_q
);

   logic r_meta;
   logic r_sync;

   // Shift the async level through two flops; reset to the line idle level.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_meta <= RESET_VALUE;
         r_sync <= RESET_VALUE;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/esc_passthrough_bridge.sv
// Half-duplex bridge between a host UART and a shared single-wire ESC pin.
// Whichever side starts talking first owns the line until it has been idle
// (high) for HOLD_CYCLES consecutive clocks.
module esc_passthrough_bridge
   import passthrough_pkg::*;
#(
   parameter int unsigned CLK_FREQ_HZ = DEF_CLK_FREQ_HZ,
   parameter int unsigned BAUD        = DEF_BAUD,
   parameter int unsigned HOLD_BITS   = DEF_HOLD_BITS
) (
   input  logic       i_sys_clk,
   input  logic       i_rst,
   input  logic       i_enable,
   input  logic       i_usb_uart_rx,
   output logic       o_usb_uart_tx,
   input  logic       i_esc_rx,
   output logic       o_esc_tx,
   output logic       o_esc_oe,
   output logic [1:0] o_state
);

   localparam int unsigned HOLD_CYCLES = hold_cycles(CLK_FREQ_HZ, BAUD, HOLD_BITS);
   localparam logic [IDLE_CNT_W-1:0] HOLD_LAST = IDLE_CNT_W'(HOLD_CYCLES - 1);

   logic                  w_usb_s;
   logic                  w_esc_s;
   logic                  w_follow;
   logic                  w_hold_done;
   logic [IDLE_CNT_W-1:0] w_cnt_inc;

   state_e                r_state;
   logic [IDLE_CNT_W-1:0] r_idle_cnt;
   logic                  r_esc_oe;
   logic                  r_esc_tx;
   logic                  r_usb_tx;

   sync_2ff #(
      .RESET_VALUE (1'b1)
   ) u_sync_usb (
      .i_clk (i_sys_clk),
      .i_rst (i_rst),
      .i_d   (i_usb_uart_rx),
      .o_q   (w_usb_s)
   );

   sync_2ff #(
      .RESET_VALUE (1'b1)
   ) u_sync_esc (
      .i_clk (i_sys_clk),
      .i_rst (i_rst),
      .i_d   (i_esc_rx),
      .o_q   (w_esc_s)
   );

   // Line currently owning the bridge and its hold-timeout condition.
   always_comb begin
      w_follow    = (r_state == StHostTx) ? w_usb_s : w_esc_s;
      w_cnt_inc   = (r_idle_cnt == '1) ? r_idle_cnt : r_idle_cnt + IDLE_CNT_W'(1);
      w_hold_done = w_follow && (r_idle_cnt == HOLD_LAST);
   end

   // Direction FSM with registered outputs; disable behaves like a soft reset.
   always_ff @(posedge i_sys_clk) begin
      if (i_rst || !i_enable) begin
         r_state    <= StIdle;
         r_idle_cnt <= '0;
         r_esc_oe   <= 1'b0;
         r_esc_tx   <= 1'b1;
         r_usb_tx   <= 1'b1;
      end else begin
         case (r_state)
            StIdle: begin
               r_idle_cnt <= '0;
               // Host wins a simultaneous start so the ESC pin is driven.
               if (!w_usb_s) begin
                  r_state  <= StHostTx;
                  r_esc_oe <= 1'b1;
                  r_esc_tx <= w_usb_s;
                  r_usb_tx <= 1'b1;
               end else if (!w_esc_s) begin
                  r_state  <= StEscTx;
                  r_esc_oe <= 1'b0;
                  r_esc_tx <= 1'b1;
                  r_usb_tx <= w_esc_s;
               end else begin
                  r_esc_oe <= 1'b0;
                  r_esc_tx <= 1'b1;
                  r_usb_tx <= 1'b1;
               end
            end
            StHostTx, StEscTx: begin
               if (w_hold_done) begin
                  r_state    <= StIdle;
                  r_idle_cnt <= '0;
                  r_esc_oe   <= 1'b0;
                  r_esc_tx   <= 1'b1;
                  r_usb_tx   <= 1'b1;
               end else begin
                  r_idle_cnt <= w_follow ? w_cnt_inc : '0;
                  r_esc_oe   <= (r_state == StHostTx);
                  r_esc_tx   <= (r_state == StHostTx) ? w_usb_s : 1'b1;
                  r_usb_tx   <= (r_state == StEscTx) ? w_esc_s : 1'b1;
               end
            end
            default: begin
               r_state    <= StIdle;
               r_idle_cnt <= '0;
               r_esc_oe   <= 1'b0;
               r_esc_tx   <= 1'b1;
               r_usb_tx   <= 1'b1;
            end
         endcase
      end
   end

   assign o_esc_oe      = r_esc_oe;
   assign o_esc_tx      = r_esc_tx;
   assign o_usb_uart_tx = r_usb_tx;
   assign o_state       = r_state;

endmodule
